// File: rtl/fdc_event_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : fdc_event_fifo_if
//  Description : Event-strobe, SPI pin and status bundle for fdc_event_fifo.
//                The master side drives MSX events and the SPI pins; the
//                slave side (the FIFO) returns serial data and status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fdc_event_fifo_if #(
  parameter int DEPTH_LOG2 = 3
);
  logic                  EV_VALID;
  logic                  EV_nLDOR;
  logic                  EV_A0;
  logic                  EV_nWR;
  logic                  EV_nRD;
  logic [7:0]            EV_DATA;
  logic                  SPI_CS;
  logic                  SPI_CLK;
  logic                  SPI_MISO;
  logic                  EV_IRQ;
  logic [DEPTH_LOG2:0]   FIFO_LEVEL;
  logic                  OVERFLOW;

  modport master (
    output EV_VALID, EV_nLDOR, EV_A0, EV_nWR, EV_nRD, EV_DATA, SPI_CS, SPI_CLK,
    input  SPI_MISO, EV_IRQ, FIFO_LEVEL, OVERFLOW
  );

  modport slave (
    input  EV_VALID, EV_nLDOR, EV_A0, EV_nWR, EV_nRD, EV_DATA, SPI_CS, SPI_CLK,
    output SPI_MISO, EV_IRQ, FIFO_LEVEL, OVERFLOW
  );
endinterface
`default_nettype wire

// File: rtl/fdc_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fdc_event_fifo
//  Description : Queues decoded MSX accesses to the WD37C65C / LDOR window and
//                hands them to the STM32 as 16-bit SPI mode-0 frames, one
//                entry per chip-select assertion. SPI pins are oversampled.
//  Revision    : 1.0 - initial release
// ============================================================================
module fdc_event_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  wire logic        MSX_CLK,
  input  wire logic        RESET,
  fdc_event_fifo_if.slave  bus
);
  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [4:0]          FRAME_BITS = 5'd16;

  // Storage keeps only the variable fields: {nLDOR, A0, nWR, nRD, DATA}.
  logic [11:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level;
  logic [DEPTH_LOG2:0]   level_next;
  logic                  irq;
  logic                  overflow;
  logic                  ovf_pend;

  logic [15:0]           shift;
  logic [4:0]            bit_cnt;
  logic                  active;

  logic                  cs_meta, cs_sync, cs_prev;
  logic                  sck_meta, sck_sync, sck_prev;

  logic                  empty, full;
  logic                  cs_fall, cs_rise, sck_fall;
  logic                  push, pop, drop;
  logic [11:0]           head;
  logic [15:0]           frame;

  assign empty    = (level == '0);
  assign full     = (level == LEVEL_FULL);
  assign cs_fall  = cs_prev & ~cs_sync;
  assign cs_rise  = ~cs_prev & cs_sync;
  assign sck_fall = sck_prev & ~sck_sync;

  // A pop only happens at the start of a frame; a full FIFO still accepts a
  // push in the same cycle because the pop frees the slot being written.
  assign pop  = cs_fall & ~empty;
  assign push = bus.EV_VALID & (~full | pop);
  assign drop = bus.EV_VALID & full & ~pop;

  assign head  = mem[rd_ptr];
  assign frame = {1'b1, head[11:8], ovf_pend, 2'b00, head[7:0]};

  assign bus.SPI_MISO   = shift[15];
  assign bus.EV_IRQ     = irq;
  assign bus.FIFO_LEVEL = level;
  assign bus.OVERFLOW   = overflow;

  // Double-flop the asynchronous SPI pins and keep one extra stage for edges.
  always_ff @(posedge MSX_CLK) begin
    if (RESET) begin
      cs_meta  <= 1'b1;
      cs_sync  <= 1'b1;
      cs_prev  <= 1'b1;
      sck_meta <= 1'b0;
      sck_sync <= 1'b0;
      sck_prev <= 1'b0;
    end else begin
      cs_meta  <= bus.SPI_CS;
      cs_sync  <= cs_meta;
      cs_prev  <= cs_sync;
      sck_meta <= bus.SPI_CLK;
      sck_sync <= sck_meta;
      sck_prev <= sck_sync;
    end
  end

  // Entry count after this cycle's push/pop; both together leave it as is.
  always_comb begin
    level_next = level;
    if (push && !pop) begin
      level_next = level + 1'b1;
    end else if (pop && !push) begin
      level_next = level - 1'b1;
    end
  end

  // Entry storage; contents need no reset because the pointers define validity.
  always_ff @(posedge MSX_CLK) begin
    if (!RESET && push) begin
      mem[wr_ptr] <= {bus.EV_nLDOR, bus.EV_A0, bus.EV_nWR, bus.EV_nRD, bus.EV_DATA};
    end
  end

  // Pointers, level, interrupt and overflow bookkeeping.
  always_ff @(posedge MSX_CLK) begin
    if (RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      irq      <= 1'b0;
      overflow <= 1'b0;
      ovf_pend <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        ovf_pend <= 1'b0;
      end
      if (drop) begin
        ovf_pend <= 1'b1;
        overflow <= 1'b1;
      end
      level <= level_next;
      irq   <= (level_next != '0);
    end
  end

  // Frame shifter: load on CS fall, clear on CS rise, shift on SCK fall.
  // Shifting is only armed by a synchronised CS fall, so SCK edges left over
  // from a transfer interrupted by reset are ignored.
  always_ff @(posedge MSX_CLK) begin
    if (RESET) begin
      shift   <= '0;
      bit_cnt <= '0;
      active  <= 1'b0;
    end else if (cs_fall) begin
      shift   <= pop ? frame : 16'h0000;
      bit_cnt <= '0;
      active  <= 1'b1;
    end else if (cs_rise) begin
      shift   <= '0;
      bit_cnt <= '0;
      active  <= 1'b0;
    end else if (active && sck_fall && (bit_cnt != FRAME_BITS)) begin
      shift   <= {shift[14:0], 1'b0};
      bit_cnt <= bit_cnt + 5'd1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_fdc_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fdc_event_fifo
//  Description : Directed, table-driven bench for fdc_event_fifo with a few
//                hand-written multi-cycle sequences for the SPI corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fdc_event_fifo;
  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  fdc_event_fifo_if #(.DEPTH_LOG2(3)) bus ();

  fdc_event_fifo #(.DEPTH_LOG2(3)) dut (
    .MSX_CLK (clk),
    .RESET   (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          do_read;
    logic [3:0]  flags;      // {nLDOR, A0, nWR, nRD}
    logic [7:0]  data;
    logic [15:0] exp_frame;
    logic [3:0]  exp_level;
    logic        exp_irq;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [22];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_ev(input logic [3:0] flags, input logic [7:0] data);
    {bus.EV_nLDOR, bus.EV_A0, bus.EV_nWR, bus.EV_nRD} = flags;
    bus.EV_DATA  = data;
    bus.EV_VALID = 1'b1;
    tick(1);
    bus.EV_VALID = 1'b0;
    tick(1);
  endtask

  task automatic spi_shift(input int nbits, output logic [15:0] val);
    val = '0;
    for (int b = 0; b < nbits; b++) begin
      val = {val[14:0], bus.SPI_MISO};
      bus.SPI_CLK = 1'b1;
      tick(4);
      bus.SPI_CLK = 1'b0;
      tick(4);
    end
  endtask

  task automatic spi_begin();
    bus.SPI_CS = 1'b0;
    tick(5);
  endtask

  task automatic spi_end();
    bus.SPI_CS = 1'b1;
    tick(5);
  endtask

  task automatic spi_read(output logic [15:0] val);
    spi_begin();
    spi_shift(16, val);
    spi_end();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic check_status(input string tag, input logic [3:0] lvl,
                              input logic irq, input logic ovf);
    check({tag, " level"}, 16'(bus.FIFO_LEVEL), 16'(lvl));
    check({tag, " irq"}, 16'(bus.EV_IRQ), 16'(irq));
    check({tag, " ovf"}, 16'(bus.OVERFLOW), 16'(ovf));
  endtask

  // Watchdog: every wait is a fixed tick count, this only guards a stuck clock.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] got;

    // Single push / read, empty read, then ten pushes into eight slots and
    // nine reads draining it (the first carries the overflow marker).
    vecs[0] = '{1'b0, 4'b1101, 8'hA5, 16'h0000, 4'd1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 4'b0000, 8'h00, 16'hE8A5, 4'd0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 4'b0000, 8'h00, 16'h0000, 4'd0, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      vecs[3 + i] = '{1'b0, 4'(i), 8'(i), 16'h0000,
                      4'((i < 8) ? i + 1 : 8), 1'b1, (i >= 8)};
    end
    for (int i = 0; i < 8; i++) begin
      vecs[13 + i] = '{1'b1, 4'b0000, 8'h00,
                       16'({1'b1, 4'(i), (i == 0), 2'b00, 8'(i)}),
                       4'(7 - i), (i != 7), 1'b1};
    end
    vecs[21] = '{1'b1, 4'b0000, 8'h00, 16'h0000, 4'd0, 1'b0, 1'b1};

    rst          = 1'b1;
    bus.EV_VALID = 1'b0;
    bus.EV_nLDOR = 1'b1;
    bus.EV_A0    = 1'b0;
    bus.EV_nWR   = 1'b1;
    bus.EV_nRD   = 1'b1;
    bus.EV_DATA  = 8'h00;
    bus.SPI_CS   = 1'b1;
    bus.SPI_CLK  = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);

    check_status("reset", 4'd0, 1'b0, 1'b0);
    check("reset miso", 16'(bus.SPI_MISO), 16'h0000);

    for (int k = 0; k < 22; k++) begin
      if (vecs[k].do_read) begin
        spi_read(got);
        check($sformatf("v%0d frame", k), got, vecs[k].exp_frame);
      end else begin
        push_ev(vecs[k].flags, vecs[k].data);
      end
      check_status($sformatf("v%0d", k), vecs[k].exp_level, vecs[k].exp_irq, vecs[k].exp_ovf);
    end

    // Full FIFO with a push landing exactly in the CS-fall pop cycle.
    do_reset();
    for (int i = 0; i < 8; i++) push_ev(4'b1010, 8'(8'h10 + i));
    check_status("full", 4'd8, 1'b1, 1'b0);
    bus.SPI_CS = 1'b0;
    tick(2);
    bus.EV_nLDOR = 1'b1; bus.EV_A0 = 1'b0; bus.EV_nWR = 1'b1; bus.EV_nRD = 1'b0;
    bus.EV_DATA  = 8'h30;
    bus.EV_VALID = 1'b1;
    tick(1);
    bus.EV_VALID = 1'b0;
    tick(2);
    check_status("coincide", 4'd8, 1'b1, 1'b0);
    spi_shift(16, got);
    spi_end();
    check("coincide frame", got, 16'hD010);
    spi_read(got);
    check("coincide next", got, 16'hD011);
    check_status("coincide after", 4'd7, 1'b1, 1'b0);

    // Aborted transfer consumes the popped entry without retry.
    do_reset();
    for (int i = 0; i < 3; i++) push_ev(4'b0110, 8'(8'h20 + i));
    spi_begin();
    spi_shift(5, got);
    spi_end();
    check("abort bits", got, 16'h0016);
    check_status("abort", 4'd2, 1'b1, 1'b0);
    spi_read(got);
    check("abort next", got, 16'hB021);

    // Reset in the middle of a transfer with the SPI master still clocking.
    do_reset();
    for (int i = 0; i < 4; i++) push_ev(4'b1111, 8'(8'h40 + i));
    spi_begin();
    spi_shift(7, got);
    check("midrst bits", got, 16'h007C);
    rst = 1'b1;
    tick(1);
    check_status("midrst", 4'd0, 1'b0, 1'b0);
    check("midrst miso", 16'(bus.SPI_MISO), 16'h0000);
    rst = 1'b0;
    spi_shift(9, got);
    spi_end();
    check("midrst tail", got, 16'h0000);
    spi_read(got);
    check("midrst next", got, 16'h0000);
    check_status("midrst end", 4'd0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
